parity_frame: RTL

PARITY_FRAME -- requirements
Module: parity_frame

---
 rtl/parity_frame.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/parity_frame.sv
// parity_frame: accumulates FRAME_LEN words of W bits and produces one
// parity bit per frame. It can also check that bit against a received parity bit.
//
// Handshake: a word transfers on a rising edge where in_valid=1 and
// in_ready=1. A result transfers on a rising edge where out_valid=1 and
// out_ready=1. Neither valid waits on its ready. abort discards whatever
// is in flight, and no transfer completes in an abort cycle.
//
// Optional feature: define PARITY_FRAME_ERRCNT_EN to add the 8-bit
// saturating err_cnt output.
module parity_frame #(
   parameter int W         = 4,
   parameter int FRAME_LEN = 4,
   parameter int ODD       = 0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          mode,
   input  logic          abort,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_data,
   input  logic          in_par,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_par,
   output logic          out_err,
   output logic          dbg_state
`ifdef PARITY_FRAME_ERRCNT_EN
   ,
   output logic [7:0]    err_cnt
`endif
);

   localparam int       CW      = $clog2(FRAME_LEN);
   localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);
   localparam logic     ODD_BIT = (ODD != 0);

   localparam logic [0:0] ST_ACC  = 1'b0;
   localparam logic [0:0] ST_HOLD = 1'b1;

   logic [0:0]    state_q, state_d;
   logic [W-1:0]  acc_q, acc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          mode_q, mode_d;
   logic          par_q, par_d;
   logic          err_q, err_d;

   logic          accept;
   logic          last_word;
   logic          par_new;
   logic          err_new;

   // A word offered together with abort is dropped.
   assign accept    = (state_q == ST_ACC) && in_valid && !abort;
   assign last_word = (cnt_q == LAST);
   assign par_new   = (^(acc_q ^ in_data)) ^ ODD_BIT;
   assign err_new   = mode_q & (par_new != in_par);

   // Next-state logic. abort takes priority over everything, including out_ready.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      par_d   = par_q;
      err_d   = err_q;
      if (abort) begin
         state_d = ST_ACC;
         acc_d   = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_ACC: begin
               if (accept) begin
                  if (last_word) begin
                     par_d   = par_new;
                     err_d   = err_new;
                     acc_d   = '0;
                     cnt_d   = '0;
                     state_d = ST_HOLD;
                  end else begin
                     acc_d = acc_q ^ in_data;
                     cnt_d = cnt_q + CW'(1);
                     // The frame's mode is taken from its first word only.
                     if (cnt_q == '0) begin
                        mode_d = mode;
                     end
                  end
               end
            end
            ST_HOLD: begin
               if (out_ready) begin
                  state_d = ST_ACC;
               end
            end
            default: begin
               state_d = ST_ACC;
            end
         endcase
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_ACC;
         acc_q   <= '0;
         cnt_q   <= '0;
         mode_q  <= 1'b0;
         par_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         par_q   <= par_d;
         err_q   <= err_d;
      end
   end

   // Handshake outputs come only from the state. The exit cycle of HOLD
   // therefore never accepts a word, which gives the one-cycle bubble.
   assign in_ready  = (state_q == ST_ACC);
   assign out_valid = (state_q == ST_HOLD);
   assign out_par   = par_q;
   assign out_err   = err_q;
   assign dbg_state = state_q[0];

`ifdef PARITY_FRAME_ERRCNT_EN
   logic [7:0] errcnt_q;
   logic       err_entry;

   assign err_entry = accept && last_word && err_new;

   // Count frames that enter HOLD with an error, saturating at 255.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         errcnt_q <= 8'd0;
      end else if (err_entry && (errcnt_q != 8'hFF)) begin
         errcnt_q <= errcnt_q + 8'd1;
      end
   end

   assign err_cnt = errcnt_q;
`endif

endmodule
